// File: rtl/i2c_target_regs_pkg.sv
`default_nettype none
// ============================================================================
// i2c_pkg : shared FSM state encoding and constants for the I2C target.
// Revision: 1.0
// ============================================================================
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        WR_BYTE  = 3'd3,
        WR_ACK   = 3'd4,
        RD_BYTE  = 3'd5,
        RD_MACK  = 3'd6
    } state_t;

    localparam logic [6:0] GENERAL_CALL = 7'h00;

    // Register index width, never narrower than one bit.
    function automatic int addr_width(input int n_regs);
        return (n_regs <= 2) ? 1 : $clog2(n_regs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_target_regs_if.sv
`default_nettype none
// ============================================================================
// i2c_target_regs_if : I2C pin bundle (SCL, SDA in, SDA open-drain control).
// Revision: 1.0
// ============================================================================
interface i2c_target_regs_if;

    logic scl;
    logic sda_in;
    logic sda_oe;
    logic sda_out;

    modport master (
        output scl,
        output sda_in,
        input  sda_oe,
        input  sda_out
    );

    modport slave (
        input  scl,
        input  sda_in,
        output sda_oe,
        output sda_out
    );

endinterface
`default_nettype wire

// File: rtl/i2c_target_regs_bus_cond.sv
`default_nettype none
// ============================================================================
// i2c_bus_cond : SCL/SDA synchroniser with edge and START/STOP detection.
// Revision: 1.0
// ============================================================================
module i2c_bus_cond (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic scl_i,
    input  wire logic sda_i,
    output logic      scl_rise_o,
    output logic      scl_fall_o,
    output logic      start_o,
    output logic      stop_o,
    output logic      sda_o
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_hist_q;
    logic       sda_hist_q;
    logic       w_scl;
    logic       w_sda;

    // Reset to the idle-bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_hist_q <= scl_sync_q[1];
            sda_hist_q <= sda_sync_q[1];
        end
    end

    assign w_scl = scl_sync_q[1];
    assign w_sda = sda_sync_q[1];

    assign scl_rise_o = w_scl & ~scl_hist_q;
    assign scl_fall_o = ~w_scl & scl_hist_q;
    assign start_o    = w_scl & scl_hist_q & sda_hist_q & ~w_sda;
    assign stop_o     = w_scl & scl_hist_q & ~sda_hist_q & w_sda;
    assign sda_o      = w_sda;

endmodule
`default_nettype wire

// File: rtl/i2c_target_regs.sv
`default_nettype none
// ============================================================================
// i2c_target_regs : I2C target exposing an N_REGS-byte register window.
// Revision: 1.0
// ============================================================================
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = 7'h64,
    parameter int         N_REGS   = 4,
    localparam int        AW       = addr_width(N_REGS)
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    i2c_target_regs_if.slave           bus,
    input  wire logic [8*N_REGS-1:0]   rd_data_i,
    output logic                       wr_en_o,
    output logic [AW-1:0]              wr_addr_o,
    output logic [7:0]                 wr_data_o,
    output logic                       busy_o,
    output logic [2:0]                 i2c_state_o
);

    state_t        state_q;
    logic [3:0]    bitcnt_q;
    logic [7:0]    shreg_q;
    logic          rw_q;
    logic          first_q;
    logic          ack_hold_q;
    logic [AW-1:0] ptr_q;
    logic          sda_oe_q;
    logic          busy_q;
    logic          wr_en_q;
    logic [AW-1:0] wr_addr_q;
    logic [7:0]    wr_data_q;

    logic          w_scl_rise;
    logic          w_scl_fall;
    logic          w_start;
    logic          w_stop;
    logic          w_sda;
    logic [7:0]    w_byte;
    logic [7:0]    w_rd_cur;
    logic [7:0]    w_rd_adv;
    logic [AW-1:0] ptr_adv_d;
    logic          w_addr_match;
    logic          w_ptr_ok;

    i2c_bus_cond u_bus_cond (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_i      (bus.scl),
        .sda_i      (bus.sda_in),
        .scl_rise_o (w_scl_rise),
        .scl_fall_o (w_scl_fall),
        .start_o    (w_start),
        .stop_o     (w_stop),
        .sda_o      (w_sda)
    );

    // Byte as it will look once the bit sampled on this scl_rise is shifted in.
    assign w_byte       = {shreg_q[6:0], w_sda};
    assign ptr_adv_d    = (ptr_q == AW'(N_REGS - 1)) ? '0 : ptr_q + AW'(1);
    assign w_rd_cur     = rd_data_i[int'(ptr_q) * 8 +: 8];
    assign w_rd_adv     = rd_data_i[int'(ptr_adv_d) * 8 +: 8];
    assign w_addr_match = (w_byte[7:1] == I2C_ADDR) && (w_byte[7:1] != GENERAL_CALL);
    assign w_ptr_ok     = ({1'b0, w_byte} < 9'(N_REGS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bitcnt_q   <= '0;
            shreg_q    <= '0;
            rw_q       <= 1'b0;
            first_q    <= 1'b0;
            ack_hold_q <= 1'b0;
            ptr_q      <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (w_stop) begin
                state_q    <= IDLE;
                sda_oe_q   <= 1'b0;
                busy_q     <= 1'b0;
                ack_hold_q <= 1'b0;
            end else if (w_start) begin
                state_q    <= ADDR;
                bitcnt_q   <= '0;
                sda_oe_q   <= 1'b0;
                ack_hold_q <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                    end

                    ADDR: begin
                        if (w_scl_rise) begin
                            shreg_q  <= w_byte;
                            bitcnt_q <= bitcnt_q + 4'd1;
                            if (bitcnt_q == 4'd7) begin
                                if (w_addr_match) begin
                                    state_q    <= ADDR_ACK;
                                    rw_q       <= w_byte[0];
                                    ack_hold_q <= 1'b0;
                                    busy_q     <= 1'b1;
                                end else begin
                                    state_q <= IDLE;
                                end
                            end
                        end
                    end

                    // First scl_fall pulls SDA for the ACK bit, second ends it.
                    ADDR_ACK, WR_ACK: begin
                        if (w_scl_fall) begin
                            if (!ack_hold_q) begin
                                sda_oe_q   <= 1'b1;
                                ack_hold_q <= 1'b1;
                            end else begin
                                ack_hold_q <= 1'b0;
                                bitcnt_q   <= '0;
                                if (state_q == ADDR_ACK && rw_q) begin
                                    shreg_q  <= w_rd_cur;
                                    sda_oe_q <= ~w_rd_cur[7];
                                    state_q  <= RD_BYTE;
                                end else begin
                                    sda_oe_q <= 1'b0;
                                    first_q  <= (state_q == ADDR_ACK);
                                    state_q  <= WR_BYTE;
                                end
                            end
                        end
                    end

                    WR_BYTE: begin
                        if (w_scl_rise) begin
                            shreg_q  <= w_byte;
                            bitcnt_q <= bitcnt_q + 4'd1;
                            if (bitcnt_q == 4'd7) begin
                                if (first_q && !w_ptr_ok) begin
                                    state_q <= IDLE;
                                    busy_q  <= 1'b0;
                                end else begin
                                    if (first_q) begin
                                        ptr_q <= w_byte[AW-1:0];
                                    end else begin
                                        wr_en_q   <= 1'b1;
                                        wr_addr_q <= ptr_q;
                                        wr_data_q <= w_byte;
                                        ptr_q     <= ptr_adv_d;
                                    end
                                    ack_hold_q <= 1'b0;
                                    state_q    <= WR_ACK;
                                end
                            end
                        end
                    end

                    RD_BYTE: begin
                        if (w_scl_rise) begin
                            shreg_q  <= {shreg_q[6:0], 1'b0};
                            bitcnt_q <= bitcnt_q + 4'd1;
                        end else if (w_scl_fall) begin
                            if (bitcnt_q == 4'd8) begin
                                sda_oe_q <= 1'b0;
                                state_q  <= RD_MACK;
                            end else begin
                                sda_oe_q <= ~shreg_q[7];
                            end
                        end
                    end

                    // Next byte is snapshotted here; its MSB goes out on the next fall.
                    RD_MACK: begin
                        if (w_scl_rise) begin
                            if (!w_sda) begin
                                ptr_q    <= ptr_adv_d;
                                shreg_q  <= w_rd_adv;
                                bitcnt_q <= '0;
                                state_q  <= RD_BYTE;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end

                    default: begin
                        state_q  <= IDLE;
                        sda_oe_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.sda_oe  = sda_oe_q;
    assign bus.sda_out = 1'b0;
    assign wr_en_o     = wr_en_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign busy_o      = busy_q;
    assign i2c_state_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regs.sv
`default_nettype none
// ============================================================================
// tb_i2c_target_regs : bit-banged I2C master driving i2c_target_regs.
// Revision: 1.0
// ============================================================================
module tb_i2c_target_regs;
    import i2c_pkg::*;

    localparam int N  = 4;
    localparam int Q  = 60;    // quarter SCL period; clk period is 10
    localparam logic [7:0] AW_ADDR = 8'hC8;
    localparam logic [7:0] AR_ADDR = 8'hC9;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic [8*N-1:0] rd_data;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic [2:0] st;

    logic [7:0] regs [N];
    int         mptr;
    int         checks = 0;
    int         errors = 0;

    int         wr_cnt = 0;
    logic [1:0] log_a [256];
    logic [7:0] log_d [256];
    int         oe_cnt = 0;

    i2c_target_regs_if bus ();
    assign bus.scl    = scl_m;
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    i2c_target_regs #(.I2C_ADDR(7'h64), .N_REGS(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .rd_data_i   (rd_data),
        .wr_en_o     (wr_en),
        .wr_addr_o   (wr_addr),
        .wr_data_o   (wr_data),
        .busy_o      (busy),
        .i2c_state_o (st)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            log_a[wr_cnt[7:0]] = wr_addr;
            log_d[wr_cnt[7:0]] = wr_data;
            wr_cnt = wr_cnt + 1;
        end
        if (bus.sda_oe) oe_cnt = oe_cnt + 1;
    end

    always_comb begin
        rd_data = '0;
        for (int r = 0; r < N; r++) rd_data[8*r +: 8] = regs[r];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        if (!scl_m) begin
            #Q sda_m = 1'b1;
            #Q scl_m = 1'b1;
        end
        #Q sda_m = 1'b0;
        #Q scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        #Q sda_m = 1'b0;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b1;
        #Q;
    endtask

    task automatic send_bit(input logic b);
        #Q sda_m = b;
        #Q scl_m = 1'b1;
        #(2*Q) scl_m = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        #Q sda_m = 1'b1;
        #Q scl_m = 1'b1;
        #Q b = bus.sda_in;
        #Q scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        recv_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] v, input logic mack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            v[i] = b;
        end
        send_bit(~mack);
    endtask

    task automatic randomize_regs();
        for (int r = 0; r < N; r++) regs[r] = 8'($urandom);
    endtask

    initial begin
        logic       ack;
        logic [7:0] v;
        int         base;
        int         p;
        int         len;
        logic [7:0] wbytes [8];

        regs[0] = 8'hA1; regs[1] = 8'hB2; regs[2] = 8'hC3; regs[3] = 8'hD4;
        mptr = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_sda_oe",  bus.sda_oe,  0);
        chk("rst_sda_out", bus.sda_out, 0);
        chk("rst_wr_en",   wr_en,       0);
        chk("rst_wr_addr", wr_addr,     0);
        chk("rst_wr_data", wr_data,     0);
        chk("rst_busy",    busy,        0);
        chk("rst_state",   st,          32'(IDLE));
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Plain read of four bytes, NACK on the last.
        i2c_start();
        write_byte(AR_ADDR, ack);
        chk("rd_addr_ack", ack, 1);
        chk("rd_busy_hi", busy, 1);
        for (int k = 0; k < 4; k++) begin
            read_byte(v, k < 3);
            chk($sformatf("rd_byte%0d", k), v, regs[(mptr + k) % N]);
        end
        mptr = (mptr + 3) % N;
        chk("rd_busy_lo", busy, 0);
        chk("rd_state_idle", st, 32'(IDLE));
        i2c_stop();

        // Pointer write, repeated START, wrapping read.
        i2c_start();
        write_byte(AW_ADDR, ack);
        chk("cmb_addr_ack", ack, 1);
        write_byte(8'h02, ack);
        chk("cmb_ptr_ack", ack, 1);
        mptr = 2;
        i2c_start();
        write_byte(AR_ADDR, ack);
        chk("cmb_raddr_ack", ack, 1);
        for (int k = 0; k < 3; k++) begin
            read_byte(v, k < 2);
            chk($sformatf("cmb_byte%0d", k), v, regs[(mptr + k) % N]);
        end
        mptr = (mptr + 2) % N;
        i2c_stop();

        // Burst write wrapping 3 -> 0.
        base = wr_cnt;
        i2c_start();
        write_byte(AW_ADDR, ack); chk("bw_addr_ack", ack, 1);
        write_byte(8'h03, ack);   chk("bw_ptr_ack", ack, 1);
        write_byte(8'h55, ack);   chk("bw_d0_ack", ack, 1);
        write_byte(8'h66, ack);   chk("bw_d1_ack", ack, 1);
        i2c_stop();
        chk("bw_count", wr_cnt - base, 2);
        chk("bw_a0", log_a[base[7:0]], 3);
        chk("bw_d0", log_d[base[7:0]], 8'h55);
        chk("bw_a1", log_a[8'(base + 1)], 0);
        chk("bw_d1", log_d[8'(base + 1)], 8'h66);
        mptr = (3 + 2) % N;

        // Foreign address: never drives SDA.
        base = oe_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        chk("mis_nack", ack, 0);
        chk("mis_no_oe", oe_cnt - base, 0);
        chk("mis_state", st, 32'(IDLE));
        i2c_stop();

        // Out-of-range pointer: NACK, no write, pointer untouched.
        base = wr_cnt;
        i2c_start();
        write_byte(AW_ADDR, ack); chk("oor_addr_ack", ack, 1);
        write_byte(8'h04, ack);   chk("oor_nack", ack, 0);
        chk("oor_no_wr", wr_cnt - base, 0);
        chk("oor_state", st, 32'(IDLE));
        i2c_stop();
        i2c_start();
        write_byte(AR_ADDR, ack);
        read_byte(v, 1'b0);
        chk("oor_ptr_kept", v, regs[mptr]);
        i2c_stop();

        // Reset while the target drives bit 4 of a read byte.
        randomize_regs();
        regs[mptr][4] = 1'b0;
        i2c_start();
        write_byte(AR_ADDR, ack);
        for (int i = 0; i < 3; i++) recv_bit(v[0]);
        #Q sda_m = 1'b1;
        #Q scl_m = 1'b1;
        #Q;
        chk("rr_driving", bus.sda_oe, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rr_release", bus.sda_oe, 0);
        chk("rr_state", st, 32'(IDLE));
        chk("rr_busy", busy, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #Q scl_m = 1'b0;
        i2c_stop();
        mptr = 0;
        i2c_start();
        write_byte(AR_ADDR, ack);
        chk("rr_addr_ack", ack, 1);
        for (int k = 0; k < 2; k++) begin
            read_byte(v, k < 1);
            chk($sformatf("rr_byte%0d", k), v, regs[(mptr + k) % N]);
        end
        mptr = (mptr + 1) % N;
        i2c_stop();

        // STOP after five data bits: partial byte discarded.
        base = wr_cnt;
        p = $urandom_range(N - 1);
        i2c_start();
        write_byte(AW_ADDR, ack);
        write_byte(8'(p), ack);
        chk("sm_ptr_ack", ack, 1);
        mptr = p;
        for (int i = 0; i < 5; i++) send_bit(1'($urandom));
        i2c_stop();
        chk("sm_no_wr", wr_cnt - base, 0);
        chk("sm_state", st, 32'(IDLE));
        chk("sm_oe", bus.sda_oe, 0);

        // Randomised burst writes followed by reads from the persisted pointer.
        for (int t = 0; t < 6; t++) begin
            randomize_regs();
            p    = $urandom_range(N - 1);
            len  = $urandom_range(1, 5);
            base = wr_cnt;
            i2c_start();
            write_byte(AW_ADDR, ack);
            write_byte(8'(p), ack);
            for (int k = 0; k < len; k++) begin
                wbytes[k] = 8'($urandom);
                write_byte(wbytes[k], ack);
                chk($sformatf("rw%0d_wack%0d", t, k), ack, 1);
            end
            i2c_stop();
            chk($sformatf("rw%0d_wcount", t), wr_cnt - base, len);
            for (int k = 0; k < len; k++) begin
                chk($sformatf("rw%0d_wa%0d", t, k), log_a[8'(base + k)], (p + k) % N);
                chk($sformatf("rw%0d_wd%0d", t, k), log_d[8'(base + k)], wbytes[k]);
            end
            mptr = (p + len) % N;
            len = $urandom_range(1, 5);
            i2c_start();
            write_byte(AR_ADDR, ack);
            for (int k = 0; k < len; k++) begin
                read_byte(v, k < len - 1);
                chk($sformatf("rw%0d_rd%0d", t, k), v, regs[(mptr + k) % N]);
            end
            mptr = (mptr + len - 1) % N;
            chk($sformatf("rw%0d_idle", t), st, 32'(IDLE));
            i2c_stop();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
